// File: rtl/decoder_pkg.sv
// decoder_pkg
// Shared definitions for the U-Net decoder path: scheduler state encoding,
// default index/dimension widths, and the per-stage geometry helper that the
// scheduler and the decoder datapath both use.
package decoder_pkg;

    localparam int STAGE_W_DEF = 3;
    localparam int DIM_W_DEF   = 16;

    // Scheduler FSM encoding (3 bits).
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CFG    = 3'd1;
    localparam logic [2:0] ST_LAUNCH = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_NEXT   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERROR  = 3'd6;

    // Stage geometry: spatial size doubles per stage (up=1), channel count
    // halves per stage (up=0). Callers truncate to their dimension width.
    function automatic logic [31:0] stage_dim(input logic [31:0] base,
                                              input logic [31:0] shift,
                                              input logic        up);
        if (up)
            return base << shift;
        else
            return base >> shift;
    endfunction

endpackage

// File: rtl/decoder_stage_scheduler_watchdog.sv
// sched_watchdog
// Cycle counter used by the decoder stage scheduler to detect a stage that
// never answers. Counts while enabled, returns to zero while cleared, and
// flags the cycle on which LIMIT cycles have been spent waiting.
//   clk    : clock
//   rst    : synchronous active-high reset
//   clear  : hold the count at zero
//   enable : count this cycle
//   expire : enabled and this is the LIMIT-th waiting cycle
module sched_watchdog #(
    parameter int LIMIT = 65535,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (enable)
            count <= count + CNT_W'(1);
    end

    // The owner leaves the waiting state on expiry, so the count never
    // runs past LIMIT-1 and cannot wrap.
    assign expire = enable && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/decoder_stage_scheduler.sv
// decoder_stage_scheduler
// Sequences the U-Net decoder stages from the bottleneck upward. Each stage
// gets a parameter-load handshake, a one-cycle start pulse, and a wait for
// its done. A watchdog bounds both waits; abort returns to idle at once.
//   clk, rst           : clock, synchronous active-high reset
//   start              : run request (accepted in IDLE/DONE/ERROR only)
//   abort              : return to IDLE, highest priority
//   cfg_req/cfg_stage  : parameter load request for the current stage
//   cfg_ack            : parameter load complete
//   dec_start          : one-cycle start pulse for dec_stage
//   dec_done           : active stage finished
//   stage_*_dim/_ch    : geometry and channel counts of the current stage
//   busy/all_done/error: run status; error_stage holds the stage that hung
module decoder_stage_scheduler
    import decoder_pkg::*;
#(
    parameter int NUM_STAGES     = 4,
    parameter int STAGE_W        = STAGE_W_DEF,
    parameter int BASE_HEIGHT    = 16,
    parameter int BASE_CHANNELS  = 1024,
    parameter int DIM_W          = DIM_W_DEF,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TO_W           = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic               cfg_req,
    output logic [STAGE_W-1:0] cfg_stage,
    input  logic               cfg_ack,
    output logic               dec_start,
    output logic [STAGE_W-1:0] dec_stage,
    input  logic               dec_done,
    output logic [DIM_W-1:0]   stage_in_dim,
    output logic [DIM_W-1:0]   stage_out_dim,
    output logic [DIM_W-1:0]   stage_in_ch,
    output logic [DIM_W-1:0]   stage_out_ch,
    output logic               busy,
    output logic               all_done,
    output logic               error,
    output logic [STAGE_W-1:0] error_stage
);

    // Parameter legality is an elaboration-time matter only.
    generate
        if (NUM_STAGES < 1 || NUM_STAGES > 8 || NUM_STAGES > (1 << STAGE_W)) begin : g_bad_stages
            $error("decoder_stage_scheduler: NUM_STAGES out of range");
        end
        if (TIMEOUT_CYCLES < 2 || (TO_W < 31 && TIMEOUT_CYCLES >= (1 << TO_W))) begin : g_bad_timeout
            $error("decoder_stage_scheduler: TIMEOUT_CYCLES does not fit TO_W");
        end
        if (DIM_W > 32) begin : g_bad_dim
            $error("decoder_stage_scheduler: DIM_W must be <= 32");
        end
    endgenerate

    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

    logic [2:0]         state;
    logic [STAGE_W-1:0] stage;
    logic               waiting;
    logic               wd_expire;

    // Counter is held at zero outside CFG/RUN, so it starts from zero on
    // every entry to a waiting state.
    assign waiting = (state == ST_CFG) || (state == ST_RUN);

    sched_watchdog #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (TO_W)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (!waiting),
        .enable (waiting),
        .expire (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            stage       <= '0;
            error_stage <= '0;
        end else if (abort) begin
            state <= ST_IDLE;
            stage <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state       <= ST_CFG;
                        stage       <= '0;
                        error_stage <= '0;
                    end
                end
                ST_CFG: begin
                    // The awaited event wins over expiry in the same cycle.
                    if (cfg_ack) begin
                        state <= ST_LAUNCH;
                    end else if (wd_expire) begin
                        state       <= ST_ERROR;
                        error_stage <= stage;
                    end
                end
                ST_LAUNCH: state <= ST_RUN;
                ST_RUN: begin
                    if (dec_done) begin
                        state <= (stage == LAST_STAGE) ? ST_DONE : ST_NEXT;
                    end else if (wd_expire) begin
                        state       <= ST_ERROR;
                        error_stage <= stage;
                    end
                end
                ST_NEXT: begin
                    // Only reached below LAST_STAGE, so no wrap is possible.
                    stage <= stage + STAGE_W'(1);
                    state <= ST_CFG;
                end
                default: begin
                    state <= ST_IDLE;
                    stage <= '0;
                end
            endcase
        end
    end

    assign cfg_req   = (state == ST_CFG);
    assign dec_start = (state == ST_LAUNCH);
    assign busy      = (state == ST_CFG) || (state == ST_LAUNCH) ||
                       (state == ST_RUN) || (state == ST_NEXT);
    assign all_done  = (state == ST_DONE);
    assign error     = (state == ST_ERROR);
    assign cfg_stage = stage;
    assign dec_stage = stage;

    // Output of stage s is the input of stage s+1; out_ch is also the skip
    // connection channel count.
    assign stage_in_dim  = DIM_W'(stage_dim(32'(BASE_HEIGHT), 32'(stage), 1'b1));
    assign stage_out_dim = DIM_W'(stage_dim(32'(BASE_HEIGHT), 32'(stage) + 32'd1, 1'b1));
    assign stage_in_ch   = DIM_W'(stage_dim(32'(BASE_CHANNELS), 32'(stage), 1'b0));
    assign stage_out_ch  = DIM_W'(stage_dim(32'(BASE_CHANNELS), 32'(stage) + 32'd1, 1'b0));

endmodule

// File: tb/tb_decoder_stage_scheduler.sv
// tb_decoder_stage_scheduler
// Directed bench for the decoder stage scheduler. A phase-level model of the
// sequencing rules runs alongside the DUT and every output is compared on
// every falling edge; literal expectations at key points pin the model.
module tb_decoder_stage_scheduler;

    localparam int NS  = 4;
    localparam int TO  = 16;
    localparam int BH  = 16;
    localparam int BC  = 1024;

    logic       clk = 1'b0;
    logic       rst, start, abort, cfg_ack, dec_done;
    logic       cfg_req, dec_start, busy, all_done, error;
    logic [2:0] cfg_stage, dec_stage, error_stage;
    logic [15:0] stage_in_dim, stage_out_dim, stage_in_ch, stage_out_ch;

    always #5 clk = ~clk;

    decoder_stage_scheduler #(
        .NUM_STAGES     (NS),
        .STAGE_W        (3),
        .BASE_HEIGHT    (BH),
        .BASE_CHANNELS  (BC),
        .DIM_W          (16),
        .TIMEOUT_CYCLES (TO),
        .TO_W           (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .cfg_req       (cfg_req),
        .cfg_stage     (cfg_stage),
        .cfg_ack       (cfg_ack),
        .dec_start     (dec_start),
        .dec_stage     (dec_stage),
        .dec_done      (dec_done),
        .stage_in_dim  (stage_in_dim),
        .stage_out_dim (stage_out_dim),
        .stage_in_ch   (stage_in_ch),
        .stage_out_ch  (stage_out_ch),
        .busy          (busy),
        .all_done      (all_done),
        .error         (error),
        .error_stage   (error_stage)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- phase-level model ----------------
    typedef enum {M_IDLE, M_CFG, M_LAUNCH, M_RUN, M_NEXT, M_DONE, M_ERR} mphase_t;
    mphase_t mp = M_IDLE;
    int  ms = 0;       // current stage
    int  mes = 0;      // stage recorded at the last hang
    int  ment = 0;     // first cycle of the current wait
    int  cyc = 0;
    bit  mvalid = 0;

    always @(posedge clk) begin
        int c;
        c = cyc;
        cyc++;
        if (rst) begin
            mp = M_IDLE; ms = 0; mes = 0;
        end else if (abort) begin
            mp = M_IDLE; ms = 0;
        end else begin
            case (mp)
                M_IDLE, M_DONE, M_ERR:
                    if (start) begin mp = M_CFG; ms = 0; mes = 0; ment = c + 1; end
                M_CFG:
                    if (cfg_ack) mp = M_LAUNCH;
                    else if (c - ment + 1 == TO) begin mp = M_ERR; mes = ms; end
                M_LAUNCH: begin mp = M_RUN; ment = c + 1; end
                M_RUN:
                    if (dec_done) mp = (ms == NS - 1) ? M_DONE : M_NEXT;
                    else if (c - ment + 1 == TO) begin mp = M_ERR; mes = ms; end
                M_NEXT: begin ms = ms + 1; mp = M_CFG; ment = c + 1; end
                default: mp = M_IDLE;
            endcase
        end
        mvalid = 1;
    end

    int nstart = 0;

    always @(negedge clk) begin
        if (mvalid) begin
            chk("cfg_req",     32'(cfg_req),       32'(mp == M_CFG));
            chk("dec_start",   32'(dec_start),     32'(mp == M_LAUNCH));
            chk("cfg_stage",   32'(cfg_stage),     32'(ms));
            chk("dec_stage",   32'(dec_stage),     32'(ms));
            chk("in_dim",      32'(stage_in_dim),  32'((BH * (1 << ms)) % 65536));
            chk("out_dim",     32'(stage_out_dim), 32'((BH * (1 << (ms + 1))) % 65536));
            chk("in_ch",       32'(stage_in_ch),   32'(BC / (1 << ms)));
            chk("out_ch",      32'(stage_out_ch),  32'(BC / (1 << (ms + 1))));
            chk("busy",        32'(busy),
                32'(mp == M_CFG || mp == M_LAUNCH || mp == M_RUN || mp == M_NEXT));
            chk("all_done",    32'(all_done),      32'(mp == M_DONE));
            chk("error",       32'(error),         32'(mp == M_ERR));
            chk("error_stage", 32'(error_stage),   32'(mes));
            if (dec_start === 1'b1) nstart++;
        end
    end

    // ---------------- stimulus ----------------
    int lit_dim[4] = '{16, 32, 64, 128};
    int lit_ch[4]  = '{1024, 512, 256, 128};

    // Drive one cycle of inputs; returns at the falling edge after it.
    task automatic drv(input logic s, input logic a, input logic k, input logic d);
        start = s; abort = a; cfg_ack = k; dec_done = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 0);
    endtask

    // Entered on the first CFG cycle of stage s: ack 3 cycles after cfg_req,
    // done 10 cycles after dec_start. Returns in NEXT/DONE, or in the next
    // stage's CFG when more stages follow.
    task automatic run_stage(input int s, input bit last);
        idle(3);
        drv(0, 0, 1, 0);
        chk("launch_pulse", 32'(dec_start), 32'd1);
        chk("launch_stage", 32'(dec_stage), 32'(s));
        chk("launch_dim",   32'(stage_in_dim), 32'(lit_dim[s]));
        chk("launch_ch",    32'(stage_in_ch),  32'(lit_ch[s]));
        idle(10);
        drv(0, 0, 0, 1);
        if (!last) idle(1);
    endtask

    initial begin
        int n0;
        rst = 1; start = 0; abort = 0; cfg_ack = 0; dec_done = 0;
        repeat (2) @(negedge clk);
        chk("rst_cfg_req",  32'(cfg_req),       32'd0);
        chk("rst_busy",     32'(busy),          32'd0);
        chk("rst_in_dim",   32'(stage_in_dim),  32'd16);
        chk("rst_out_dim",  32'(stage_out_dim), 32'd32);
        chk("rst_in_ch",    32'(stage_in_ch),   32'd1024);
        chk("rst_out_ch",   32'(stage_out_ch),  32'd512);
        rst = 0;

        // Full four-stage run.
        nstart = 0;
        drv(1, 0, 0, 0);
        chk("t1_cfg_req", 32'(cfg_req), 32'd1);
        for (int s = 0; s < NS; s++) run_stage(s, s == NS - 1);
        chk("t1_all_done", 32'(all_done), 32'd1);
        chk("t1_busy",     32'(busy),     32'd0);
        chk("t1_pulses",   32'(nstart),   32'd4);

        // Hang in stage 2 RUN; error exactly 16 cycles after RUN entry.
        drv(1, 0, 0, 0);
        run_stage(0, 0);
        run_stage(1, 0);
        idle(3);
        drv(0, 0, 1, 0);
        chk("t2_stage", 32'(dec_stage), 32'd2);
        idle(16);
        chk("t2_no_err_yet", 32'(error), 32'd0);
        idle(1);
        chk("t2_error",     32'(error),       32'd1);
        chk("t2_err_stage", 32'(error_stage), 32'd2);
        n0 = nstart;
        idle(5);
        chk("t2_no_pulse", 32'(nstart - n0), 32'd0);
        drv(1, 0, 0, 0);
        chk("t2_restart_req",   32'(cfg_req),     32'd1);
        chk("t2_restart_stage", 32'(cfg_stage),   32'd0);
        chk("t2_restart_err",   32'(error),       32'd0);
        chk("t2_restart_estg",  32'(error_stage), 32'd0);

        // dec_done on the RUN expiry cycle of stage 1, then cfg_ack on the
        // CFG expiry cycle of stage 2.
        run_stage(0, 0);
        idle(3);
        drv(0, 0, 1, 0);
        idle(16);
        drv(0, 0, 0, 1);
        chk("t3_no_error", 32'(error), 32'd0);
        chk("t3_busy",     32'(busy),  32'd1);
        idle(1);
        chk("t3_cfg_req",   32'(cfg_req),   32'd1);
        chk("t3_cfg_stage", 32'(cfg_stage), 32'd2);
        idle(15);
        drv(0, 0, 1, 0);
        chk("t3_launch", 32'(dec_start), 32'd1);
        chk("t3_cfg_err", 32'(error),    32'd0);
        // Abort during LAUNCH: single pulse, back to idle.
        drv(0, 1, 0, 0);
        chk("t3_abort_pulse", 32'(dec_start), 32'd0);
        chk("t3_abort_busy",  32'(busy),      32'd0);
        chk("t3_abort_stage", 32'(dec_stage), 32'd0);

        // Abort together with dec_done in stage 1 RUN.
        drv(1, 0, 0, 0);
        run_stage(0, 0);
        idle(3);
        drv(0, 0, 1, 0);
        idle(4);
        drv(0, 1, 0, 1);
        chk("t4_busy",     32'(busy),         32'd0);
        chk("t4_stage",    32'(dec_stage),    32'd0);
        chk("t4_all_done", 32'(all_done),     32'd0);
        chk("t4_error",    32'(error),        32'd0);
        chk("t4_in_dim",   32'(stage_in_dim), 32'd16);
        idle(2);

        // start held while busy; dec_done in LAUNCH ignored.
        drv(1, 0, 0, 0);
        idle(3);
        drv(0, 0, 1, 0);
        drv(1, 0, 0, 1);
        chk("t5_run_busy",  32'(busy),      32'd1);
        chk("t5_run_req",   32'(cfg_req),   32'd0);
        chk("t5_run_stage", 32'(dec_stage), 32'd0);
        for (int i = 0; i < 5; i++) drv(1, 0, 0, 0);
        chk("t5_still_run", 32'(dec_stage), 32'd0);
        chk("t5_still_req", 32'(cfg_req),   32'd0);
        drv(1, 0, 0, 1);
        drv(1, 0, 0, 0);
        chk("t5_next_req",   32'(cfg_req),   32'd1);
        chk("t5_next_stage", 32'(cfg_stage), 32'd1);

        // Reset in the middle of stage 3 CFG.
        run_stage(1, 0);
        run_stage(2, 0);
        chk("t6_cfg_stage", 32'(cfg_stage), 32'd3);
        idle(1);
        rst = 1;
        idle(1);
        rst = 0;
        chk("t6_cfg_req",  32'(cfg_req),       32'd0);
        chk("t6_busy",     32'(busy),          32'd0);
        chk("t6_stage",    32'(cfg_stage),     32'd0);
        chk("t6_in_dim",   32'(stage_in_dim),  32'd16);
        chk("t6_out_ch",   32'(stage_out_ch),  32'd512);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
